vend_dispense_ctrl: RTL and testbench

- Credit-and-dispense controller for the vending datapath.
- Accumulates coin credit in nickel units and enforces a maximum credit.
- On a product select with enough credit, it issues a timed product-release pulse, then pays change out as a train of nickel pulses.
- Sits between the coin-acceptor pulses and the product/change actuators. All payout sequencing happens here, with no simulation delays.

---
 rtl/vend_pkg.sv | 31 +++
 rtl/vend_pulse_timer.sv | 27 ++
 rtl/vend_dispense_ctrl.sv | 149 ++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit/dispense controller.
package vend_pkg;

  // Controller phases; encodings are fixed so they can be read off a bus or trace.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StVend  = 2'd1,
    StChgHi = 2'd2,
    StChgLo = 2'd3
  } state_e;

  // Coin values in nickel units.
  localparam int unsigned NICKEL_N  = 1;
  localparam int unsigned DIME_N    = 2;
  localparam int unsigned QUARTER_N = 5;

  // Value of the highest-value coin present; lower coins in the same cycle are ignored.
  function automatic logic [2:0] coin_value(input logic ni, input logic di, input logic qu);
    logic [2:0] val;
    val = 3'd0;
    if (qu) begin
      val = 3'(QUARTER_N);
    end else if (di) begin
      val = 3'(DIME_N);
    end else if (ni) begin
      val = 3'(NICKEL_N);
    end
    return val;
  endfunction

endpackage

// File: rtl/vend_pulse_timer.sv
// Loadable down-counter shared by the vend, change-high and change-low phases.
module vend_pulse_timer #(
  parameter int unsigned W = 3
) (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // Reload on phase entry, otherwise count down and hold at zero.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Credit accumulation, product release and nickel change payout for the vending datapath.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE_N      = 9,
  parameter int unsigned MAX_CREDIT_N = 13,
  parameter int unsigned CREDIT_W     = 4,
  parameter int unsigned PULSE_CYC    = 4,
  parameter int unsigned GAP_CYC      = 2
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                ni,
  input  logic                di,
  input  logic                qu,
  input  logic                soda,
  input  logic                diet,
  input  logic                cancel,
  output logic                giveSoda,
  output logic                giveDiet,
  output logic                change,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam int unsigned TimerMax = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned TimerW   = $clog2(TimerMax) + 1;
  localparam int unsigned SumW     = CREDIT_W + 1;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                prod_soda_q, prod_soda_d;
  logic                give_soda_q, give_diet_q, change_q, coin_reject_q, busy_q;
  logic                coin_rej_d;

  logic                tmr_load;
  logic [TimerW-1:0]   tmr_val;
  logic                tmr_done;

  logic                coin_any, coin_multi;
  logic [2:0]          coin_val;
  logic [SumW-1:0]     credit_sum;
  logic                can_vend;

  vend_pulse_timer #(
    .W (TimerW)
  ) u_timer (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Coin decode: the highest coin is evaluated, a simultaneous second coin forces a reject.
  always_comb begin
    coin_any   = ni | di | qu;
    coin_multi = (ni & di) | (ni & qu) | (di & qu);
    coin_val   = coin_value(ni, di, qu);
    credit_sum = SumW'(credit_q) + SumW'(coin_val);
    can_vend   = (soda | diet) && (credit_q >= CREDIT_W'(PRICE_N));
  end

  // Next-state, credit update and coin-reject decision.
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    prod_soda_d = prod_soda_q;
    coin_rej_d  = coin_any;  // any coin outside of IDLE acceptance is rejected
    unique case (state_q)
      StIdle: begin
        if (can_vend) begin
          state_d     = StVend;
          credit_d    = credit_q - CREDIT_W'(PRICE_N);
          prod_soda_d = soda;
        end else if (cancel && (credit_q != '0)) begin
          state_d = StChgHi;
        end else if (coin_any) begin
          if (credit_sum <= SumW'(MAX_CREDIT_N)) begin
            credit_d   = credit_sum[CREDIT_W-1:0];
            coin_rej_d = coin_multi;
          end
        end
      end
      StVend: begin
        if (tmr_done) begin
          state_d = (credit_q != '0) ? StChgHi : StIdle;
        end
      end
      StChgHi: begin
        if (tmr_done) begin
          state_d = StChgLo;
          if (credit_q != '0) begin
            credit_d = credit_q - CREDIT_W'(1);
          end
        end
      end
      StChgLo: begin
        if (tmr_done) begin
          state_d = (credit_q != '0) ? StChgHi : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Timer reloads on every state change with the length of the phase being entered.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    if (state_d == StChgLo) begin
      tmr_val = TimerW'(GAP_CYC - 1);
    end else if (state_d != StIdle) begin
      tmr_val = TimerW'(PULSE_CYC - 1);
    end
  end

  // State, credit and registered outputs; outputs follow the state being entered.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      credit_q      <= '0;
      prod_soda_q   <= 1'b0;
      give_soda_q   <= 1'b0;
      give_diet_q   <= 1'b0;
      change_q      <= 1'b0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      prod_soda_q   <= prod_soda_d;
      give_soda_q   <= (state_d == StVend) && prod_soda_d;
      give_diet_q   <= (state_d == StVend) && !prod_soda_d;
      change_q      <= (state_d == StChgHi);
      coin_reject_q <= coin_rej_d;
      busy_q        <= (state_d != StIdle);
    end
  end

  assign giveSoda    = give_soda_q;
  assign giveDiet    = give_diet_q;
  assign change      = change_q;
  assign coin_reject = coin_reject_q;
  assign busy        = busy_q;
  assign credit      = credit_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Scoreboard bench: a dispense-plan model predicts every output cycle; a monitor compares.
module tb_vend_dispense_ctrl;

  localparam int PRICE_N      = 9;
  localparam int MAX_CREDIT_N = 13;
  localparam int CREDIT_W     = 4;
  localparam int PULSE_CYC    = 4;
  localparam int GAP_CYC      = 2;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  logic ni = 1'b0, di = 1'b0, qu = 1'b0, soda = 1'b0, diet = 1'b0, cancel = 1'b0;
  logic giveSoda, giveDiet, change, coin_reject, busy;
  logic [CREDIT_W-1:0] credit;

  vend_dispense_ctrl #(
    .PRICE_N      (PRICE_N),
    .MAX_CREDIT_N (MAX_CREDIT_N),
    .CREDIT_W     (CREDIT_W),
    .PULSE_CYC    (PULSE_CYC),
    .GAP_CYC      (GAP_CYC)
  ) dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .ni          (ni),
    .di          (di),
    .qu          (qu),
    .soda        (soda),
    .diet        (diet),
    .cancel      (cancel),
    .giveSoda    (giveSoda),
    .giveDiet    (giveDiet),
    .change      (change),
    .coin_reject (coin_reject),
    .busy        (busy),
    .credit      (credit)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       gs;
    logic       gd;
    logic       chg;
    logic       rej;
    logic       busy;
    logic [3:0] cr;
  } frame_t;

  frame_t plan[$];   // upcoming output frames of an accepted vend/refund
  frame_t expq[$];   // scoreboard: expected output after each clock edge
  int     m_credit = 0;
  bit     m_busy   = 1'b0;
  bit     chk_en   = 1'b0;
  int     n_checks = 0;
  int     n_errors = 0;

  function automatic frame_t mk(bit gs, bit gd, bit chg, bit bsy, int cr);
    frame_t f;
    f.gs = gs; f.gd = gd; f.chg = chg; f.rej = 1'b0; f.busy = bsy; f.cr = 4'(cr);
    return f;
  endfunction

  // Change payout of n nickels: each nickel is a high pulse then a gap; credit drops at the gap.
  task automatic add_change(int n);
    for (int k = n; k >= 1; k--) begin
      repeat (PULSE_CYC) plan.push_back(mk(0, 0, 1, 1, k));
      repeat (GAP_CYC) plan.push_back(mk(0, 0, 0, 1, k - 1));
    end
  endtask

  // Evaluates the inputs seen at a clock edge and queues the output expected after it.
  task automatic model_step();
    int     nc, val;
    bit     rej;
    frame_t f;
    nc  = int'(ni) + int'(di) + int'(qu);
    val = qu ? 5 : (di ? 2 : (ni ? 1 : 0));
    rej = 1'b0;
    if (m_busy) begin
      rej = (nc > 0);
    end else if ((soda || diet) && m_credit >= PRICE_N) begin
      m_credit -= PRICE_N;
      repeat (PULSE_CYC) plan.push_back(mk(soda, !soda, 0, 1, m_credit));
      add_change(m_credit);
      m_credit = 0;
      rej = (nc > 0);
    end else if (cancel && m_credit > 0) begin
      add_change(m_credit);
      m_credit = 0;
      rej = (nc > 0);
    end else if (nc > 0) begin
      if (m_credit + val <= MAX_CREDIT_N) begin
        m_credit += val;
        rej = (nc > 1);
      end else begin
        rej = 1'b1;
      end
    end
    if (plan.size() > 0) f = plan.pop_front();
    else f = mk(0, 0, 0, 0, m_credit);
    f.rej  = rej;
    m_busy = f.busy;
    expq.push_back(f);
  endtask

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: DUT outputs are compared mid-cycle against the oldest prediction.
  always @(negedge CLK) begin
    frame_t e, a;
    if (chk_en && expq.size() > 0) begin
      e = expq.pop_front();
      a = {giveSoda, giveDiet, change, coin_reject, busy, credit};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL frame @%0t: got gs=%b gd=%b chg=%b rej=%b busy=%b cr=%0d expected gs=%b gd=%b chg=%b rej=%b busy=%b cr=%0d",
                 $time, a.gs, a.gd, a.chg, a.rej, a.busy, a.cr,
                 e.gs, e.gd, e.chg, e.rej, e.busy, e.cr);
      end
    end
  end

  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic set_in(logic n, logic d, logic q, logic s, logic dt, logic c);
    ni = n; di = d; qu = q; soda = s; diet = dt; cancel = c;
  endtask

  task automatic idle(int n);
    set_in(0, 0, 0, 0, 0, 0);
    repeat (n) cycle();
  endtask

  task automatic drive1(logic n, logic d, logic q, logic s, logic dt, logic c);
    set_in(n, d, q, s, dt, c);
    cycle();
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    check("reset giveSoda", int'(giveSoda), 0);
    check("reset change", int'(change), 0);
    check("reset busy", int'(busy), 0);
    check("reset credit", int'(credit), 0);
    @(posedge CLK);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // 1: two quarters then soda, one nickel of change
    drive1(0, 0, 1, 0, 0, 0);
    drive1(0, 0, 1, 0, 0, 0);
    drive1(0, 0, 0, 1, 0, 0);
    idle(14);

    // 2: third quarter would overflow the ceiling; then refund
    drive1(0, 0, 1, 0, 0, 0);
    drive1(0, 0, 1, 0, 0, 0);
    drive1(0, 0, 1, 0, 0, 0);
    idle(2);
    drive1(0, 0, 0, 0, 0, 1);
    idle(65);

    // 3: dime then cancel, two change pulses
    drive1(0, 1, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0, 1);
    idle(16);

    // 4: short credit ignored, exact credit vends diet with no change
    drive1(0, 0, 1, 0, 0, 0);
    drive1(0, 1, 0, 0, 0, 0);
    drive1(1, 0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 1, 0);
    idle(2);
    drive1(1, 0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 1, 0);
    idle(8);

    // 5: coin during the second giveSoda cycle is rejected
    drive1(0, 0, 1, 0, 0, 0);
    drive1(0, 0, 1, 0, 0, 0);
    drive1(0, 0, 0, 1, 0, 0);
    drive1(1, 0, 0, 0, 0, 0);
    idle(14);

    // Simultaneous coins: highest counts, reject flagged
    drive1(1, 0, 1, 0, 0, 0);
    drive1(0, 0, 0, 0, 0, 1);
    idle(40);

    // 6: asynchronous reset in the middle of a change pulse
    drive1(0, 1, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0, 1);
    cycle();
    check("change before reset", int'(change), 1);
    chk_en = 1'b0;
    expq.delete();
    rst_n = 1'b0;
    #1;
    check("reset drops change", int'(change), 0);
    check("reset clears credit", int'(credit), 0);
    check("reset clears busy", int'(busy), 0);
    plan.delete();
    m_credit = 0;
    m_busy   = 1'b0;
    @(posedge CLK);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    drive1(1, 0, 0, 0, 0, 0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      set_in(r < 8 || r == 20, r >= 8 && r < 14 || r == 21, r >= 14 && r < 21,
             $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0);
      cycle();
    end
    idle(120);
    @(negedge CLK);
    #1;
    check("scoreboard drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
